// File: rtl/filtro_pkg.sv
// Shared widths, saturation limits and sequencer states for the fixed-point IIR filter.
package filtro_pkg;

    localparam int W    = 22;
    localparam int FRAC = 12;
    localparam int PROD = 44;
    localparam int ACC  = 47;
    localparam int DAC  = 14;

    localparam logic signed [ACC-1:0] SAT_HI = 47'sd2097151;
    localparam logic signed [ACC-1:0] SAT_LO = -47'sd2097152;
    localparam logic signed [W-1:0]   Y_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   Y_MIN  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        UPD,
        DONE
    } state_t;

endpackage

// File: rtl/filtro_mac.sv
// Shared signed 22x22 multiplier with 47-bit accumulator, plus the Q10.12 shift/saturate stage.
// Result and clamp flag are combinational from the accumulator register.
module filtro_mac
    import filtro_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic signed [W-1:0] coef_i,
    input  logic signed [W-1:0] opnd_i,
    output logic signed [W-1:0] res_o,
    output logic                sat_o
);

    logic signed [PROD-1:0] prod;
    logic signed [ACC-1:0]  acc_q;
    logic signed [ACC-1:0]  acc_d;
    logic signed [ACC-1:0]  shifted;

    always_comb begin
        prod = coef_i * opnd_i;
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC-PROD){prod[PROD-1]}}, prod};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Arithmetic shift truncates toward minus infinity before clamping.
    always_comb begin
        shifted = acc_q >>> FRAC;
        res_o   = shifted[W-1:0];
        sat_o   = 1'b0;
        if (shifted > SAT_HI) begin
            res_o = Y_MAX;
            sat_o = 1'b1;
        end else if (shifted < SAT_LO) begin
            res_o = Y_MIN;
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/filtro_con_fsm.sv
// Second-order IIR filter: FSM sequences five MACs per sample through one shared multiplier.
// 8 cycles per sample; strobes arriving while busy are dropped.
module filtro_con_fsm #(
    parameter int                W  = 22,
    parameter logic signed [W-1:0] B0 = 22'sd2048,
    parameter logic signed [W-1:0] B1 = 22'sd1024,
    parameter logic signed [W-1:0] B2 = 22'sd0,
    parameter logic signed [W-1:0] A1 = 22'sd1024,
    parameter logic signed [W-1:0] A2 = 22'sd0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_done_tick,
    input  logic signed [W-1:0] Uk,
    output logic                listo,
    output logic signed [W-1:0] yk,
    output logic                salidawar1,
    output logic [13:0]         salidawar2
);

    import filtro_pkg::state_t;
    import filtro_pkg::IDLE;
    import filtro_pkg::MAC;
    import filtro_pkg::UPD;
    import filtro_pkg::DONE;

    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;

    logic signed [W-1:0] u0_q, u1_q, u2_q, y1_q, y2_q;
    logic signed [W-1:0] yk_q;
    logic                war1_q;
    logic [13:0]         war2_q;
    logic                listo_q;

    logic                capture;
    logic                mac_clr;
    logic                mac_en;
    logic                upd;
    logic signed [W-1:0] coef;
    logic signed [W-1:0] opnd;
    logic signed [W-1:0] res;
    logic                sat;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_done_tick) begin
                    capture = 1'b1;
                    mac_clr = 1'b1;
                    idx_d   = 3'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (idx_q == 3'd4) begin
                    state_d = UPD;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            UPD: begin
                upd     = 1'b1;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Term order: feed-forward taps first, then feedback taps.
    always_comb begin
        coef = A2;
        opnd = y2_q;
        case (idx_q)
            3'd0: begin coef = B0; opnd = u0_q; end
            3'd1: begin coef = B1; opnd = u1_q; end
            3'd2: begin coef = B2; opnd = u2_q; end
            3'd3: begin coef = A1; opnd = y1_q; end
            default: begin coef = A2; opnd = y2_q; end
        endcase
    end

    filtro_mac u_mac (
        .clk    (clk),
        .rst    (reset),
        .clr_i  (mac_clr),
        .en_i   (mac_en),
        .coef_i (coef),
        .opnd_i (opnd),
        .res_o  (res),
        .sat_o  (sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            u0_q    <= '0;
            u1_q    <= '0;
            u2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            yk_q    <= '0;
            war1_q  <= 1'b0;
            war2_q  <= '0;
            listo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            listo_q <= (state_d == DONE);
            if (capture) begin
                u0_q <= Uk;
            end
            if (upd) begin
                yk_q   <= res;
                war1_q <= sat;
                war2_q <= res[W-1 -: 14];
                u1_q   <= u0_q;
                u2_q   <= u1_q;
                y1_q   <= res;
                y2_q   <= y1_q;
            end
        end
    end

    assign listo      = listo_q;
    assign yk         = yk_q;
    assign salidawar1 = war1_q;
    assign salidawar2 = war2_q;

endmodule

// File: tb/tb_filtro_con_fsm.sv
// Scoreboard bench: two filter instances (default and unity-gain coefficients) share stimulus.
module tb_filtro_con_fsm;

    typedef struct {
        longint y;
        bit     sat;
        int     edge_n;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               rx_done_tick;
    logic signed [21:0] Uk;
    logic               listo_a, listo_b;
    logic [21:0]        yk_a, yk_b;
    logic               war1_a, war1_b;
    logic [13:0]        war2_a, war2_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = -1000;

    exp_t   q_a[$];
    exp_t   q_b[$];
    longint coef[2][5];
    longint hu1[2], hu2[2], hy1[2], hy2[2], last_y[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    filtro_con_fsm dut_a (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .Uk(Uk),
        .listo(listo_a), .yk(yk_a), .salidawar1(war1_a), .salidawar2(war2_a)
    );

    filtro_con_fsm #(.B0(22'sd4096), .A1(22'sd4096)) dut_b (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .Uk(Uk),
        .listo(listo_b), .yk(yk_b), .salidawar1(war1_b), .salidawar2(war2_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Difference equation evaluated directly in 64-bit integers.
    task automatic model_step(input int i, input longint u, output longint y, output bit sat);
        longint s;
        s = coef[i][0]*u + coef[i][1]*hu1[i] + coef[i][2]*hu2[i]
          + coef[i][3]*hy1[i] + coef[i][4]*hy2[i];
        s = s >>> 12;
        sat = 1'b0;
        if (s > 64'sd2097151) begin
            s = 2097151;
            sat = 1'b1;
        end else if (s < -64'sd2097152) begin
            s = -2097152;
            sat = 1'b1;
        end
        hu2[i] = hu1[i];
        hu1[i] = u;
        hy2[i] = hy1[i];
        hy1[i] = s;
        y = s;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            hu1[i] = 0; hu2[i] = 0; hy1[i] = 0; hy2[i] = 0; last_y[i] = 0;
        end
        q_a.delete();
        q_b.delete();
        last_acc = -1000;
    endtask

    task automatic mon_one(input int i, input logic [21:0] y, input logic w1, input logic [13:0] w2);
        exp_t   x;
        longint ye;
        logic [21:0] yv;
        if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_listo[%0d]: got listo=1, expected no pulse (cycle %0d)", i, cyc);
        end else begin
            x = (i == 0) ? q_a.pop_front() : q_b.pop_front();
            ye = x.y;
            yv = ye[21:0];
            check($sformatf("yk[%0d]", i), longint'($signed(y)), x.y);
            check($sformatf("salidawar1[%0d]", i), longint'(w1), longint'(x.sat));
            check($sformatf("salidawar2[%0d]", i), longint'(w2), longint'(yv[21:8]));
            check($sformatf("listo_latency[%0d]", i), longint'(cyc), longint'(x.edge_n));
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (listo_a) mon_one(0, yk_a, war1_a, war2_a);
            if (listo_b) mon_one(1, yk_b, war1_b, war2_b);
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        rx_done_tick = 1'b0;
        model_clear();
        repeat (n) @(negedge clk);
        check("rst_yk", longint'($signed(yk_a)) + longint'($signed(yk_b)), 0);
        check("rst_listo", longint'(listo_a) + longint'(listo_b), 0);
        check("rst_war1", longint'(war1_a) + longint'(war1_b), 0);
        check("rst_war2", longint'(war2_a) + longint'(war2_b), 0);
        reset = 1'b0;
    endtask

    task automatic send(input logic signed [21:0] u);
        int     e;
        bit     acc;
        longint y;
        bit     s;
        longint prev0, prev1;
        exp_t   x;
        @(negedge clk);
        rx_done_tick = 1'b1;
        Uk = u;
        e = cyc + 1;
        acc = (e - last_acc) >= 8;
        prev0 = last_y[0];
        prev1 = last_y[1];
        if (acc) begin
            last_acc = e;
            model_step(0, longint'(u), y, s);
            x.y = y; x.sat = s; x.edge_n = e + 6;
            q_a.push_back(x);
            last_y[0] = y;
            model_step(1, longint'(u), y, s);
            x.y = y; x.sat = s; x.edge_n = e + 6;
            q_b.push_back(x);
            last_y[1] = y;
        end
        @(negedge clk);
        rx_done_tick = 1'b0;
        Uk = 22'($urandom);
        if (acc) begin
            check("lag_yk[0]", longint'($signed(yk_a)), prev0);
            check("lag_yk[1]", longint'($signed(yk_b)), prev1);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    longint imp_exp[8];
    int     gap;
    int     sel;
    logic signed [21:0] ur;
    logic [21:0] tmp;

    initial begin
        coef[0] = '{2048, 1024, 0, 1024, 0};
        coef[1] = '{4096, 1024, 0, 4096, 0};
        imp_exp = '{2048, 1536, 384, 96, 24, 6, 1, 0};
        reset = 1'b1;
        rx_done_tick = 1'b0;
        Uk = '0;
        model_clear();

        do_reset(5);

        // Reset landing in the middle of a computation.
        send(22'sd4096);
        wait_cycles(2);
        do_reset(5);
        send(22'sd0);
        wait_cycles(15);
        check("zero_after_rst", longint'($signed(yk_a)), 0);

        // Impulse response with default coefficients.
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 22'sd4096 : 22'sd0);
            wait_cycles(15);
            check($sformatf("impulse[%0d]", i), longint'($signed(yk_a)), imp_exp[i]);
        end

        do_reset(2);
        send(-22'sd4096);
        wait_cycles(15);
        check("neg_yk", longint'(yk_a), longint'(22'h3FF800));
        check("neg_dac", longint'(war2_a), longint'(14'h3FF8));

        do_reset(2);
        send(22'sd1);
        wait_cycles(15);
        check("trunc_yk", longint'($signed(yk_a)), 0);

        // Unity-gain instance drives the accumulator past full scale.
        do_reset(2);
        tmp = 22'h1FFFFF;
        send($signed(tmp));
        wait_cycles(15);
        check("sat1_war1", longint'(war1_b), 0);
        send($signed(tmp));
        wait_cycles(15);
        check("sat2_yk", longint'(yk_b), longint'(22'h1FFFFF));
        check("sat2_war1", longint'(war1_b), 1);
        do_reset(2);
        send(22'sd0);
        wait_cycles(15);
        check("sat_clear_war1", longint'(war1_b), 0);

        // Strobe while busy must be dropped.
        send(22'sd4096);
        wait_cycles(1);
        send(22'sd8192);
        wait_cycles(14);
        send(22'sd0);
        wait_cycles(15);

        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                ur = 22'($urandom);
            end else if (sel == 1) begin
                ur = (($urandom_range(0, 1) == 1) ? 22'sh1FFFFF : 22'sh200000);
            end else begin
                ur = 22'($urandom_range(0, 16383)) - 22'sd8192;
            end
            send(ur);
            if ($urandom_range(0, 39) == 0) begin
                wait_cycles($urandom_range(0, 6));
                do_reset($urandom_range(1, 3));
            end
            gap = $urandom_range(0, 14);
            wait_cycles(gap);
        end

        wait_cycles(20);
        check("drain_queues", longint'(q_a.size() + q_b.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
